alu_seq: RTL
============

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, datapath width; legal values power of two, 4..64.
REQ-002 SHALL derive SHW = log2(WIDTH), shift-count width.
REQ-003 SHALL have one clock; reset is synchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous active-low reset.
REQ-006 in_valid  input  1  operation request.
REQ-007 in_ready  output  1  high when the unit can accept a request.
REQ-008 op  input  4  operation code.
REQ-009 a  input  WIDTH  operand A.
REQ-010 b  input  WIDTH  operand B.
REQ-011 out_valid  output  1  result and flags valid.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 result  output  WIDTH  registered result.
REQ-014 flags  output  4  registered {N,Z,C,V}.

Function
REQ-015 Op codes SHALL be: 0 NOP, 1 PASSA, 2 PASSB, 3 ADD, 4 ADDC (a+b+Cstored), 5 SUB (a-b), 6 SUBR (b-a), 7 AND, 8 OR, 9 XOR (all bitwise), A NOT a, B SHL, C SHR logical, D ASR, E MUL (low WIDTH bits, unsigned), F reserved.
REQ-016 The FSM SHALL have states IDLE, BUSY, DONE; in_ready = 1 only in IDLE.
REQ-017 Acceptance SHALL occur on a clock edge with in_valid=1 and in_ready=1; op, a, b are captured at that edge and later input changes have no effect.
REQ-018 Single-cycle ops (0-A, F) SHALL go IDLE->DONE, out_valid high the cycle after acceptance (latency 1).
REQ-019 Shift ops SHALL go IDLE->BUSY, shifting one bit per cycle for count = b[SHW-1:0]; out_valid rises count+1 cycles after acceptance (count 0: 1 cycle, result = a).
REQ-020 MUL SHALL go IDLE->BUSY, shift-and-add one bit of b per cycle; out_valid rises WIDTH+1 cycles after acceptance.
REQ-021 DONE SHALL hold result, flags, out_valid stable until an edge with out_ready=1, then go to IDLE; out_valid deasserts in that next cycle.
REQ-022 A new request SHALL be accepted no earlier than the cycle after DONE->IDLE (no overlap; max throughput one op per two cycles).
REQ-023 Arithmetic SHALL wrap modulo 2^WIDTH.
REQ-024 Z = (result==0); N = result[WIDTH-1]; for every op including NOP, PASS, reserved.
REQ-025 C: ADD/ADDC carry out; SUB/SUBR borrow (1 when minuend < subtrahend, unsigned); shifts last bit shifted out (0 if count 0); MUL 1 when upper WIDTH bits of full product nonzero; all other ops 0.
REQ-026 V: ADD/ADDC/SUB/SUBR signed two's-complement overflow; all other ops 0.
REQ-027 Cstored SHALL update with C when an op completes (enters DONE) and is used by the next ADDC.
REQ-028 NOP and reserved F SHALL produce result 0 (Z=1) and complete normally; they do not alter Cstored other than writing C=0.

Reset
REQ-029 When reset=0 at an edge: state IDLE, result 0, flags 0, Cstored 0, out_valid 0, in_ready 1 from the next cycle.
REQ-030 Reset SHALL take priority over acceptance and completion, and abort any BUSY operation with no output produced.

Verification
REQ-031 WIDTH=8: ADD a=0xFF b=0x01 -> after 1 cycle result 0x00, flags N0 Z1 C1 V0; then ADDC a=0x00 b=0x00 -> result 0x01.
REQ-032 SUB a=0x80 b=0x01 -> result 0x7F, N0 Z0 C0 V1; SUBR a=0x05 b=0x03 -> 0xFE, N1 C1 V0.
REQ-033 SHL a=0x81 b=0x03 -> out_valid 4 cycles after acceptance, result 0x08, C0; ASR a=0x80 b=0x07 -> 0xFF, 8 cycles.
REQ-034 MUL a=0x0F b=0x11 -> result 0xFF, C0 after 9 cycles; MUL a=0x10 b=0x10 -> 0x00, Z1 C1.
REQ-035 Backpressure: hold out_ready=0 5 cycles in DONE with in_valid=1 -> result/flags stable, in_ready=0, no acceptance; out_ready=1 -> IDLE next cycle.
REQ-036 Reset=0 in cycle 4 of a MUL -> next cycle out_valid 0, result 0, in_ready 1; subsequent ADD 0x02+0x03 -> 0x05.

Source files
------------

// File: rtl/alu_seq.sv
// Sequential ALU: most ops finish in one cycle, shifts move one bit per cycle and MUL
// does shift-and-add over WIDTH cycles. The result is held in DONE until the consumer takes it.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);
  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  localparam logic [3:0] OP_PASSA = 4'h1, OP_PASSB = 4'h2, OP_ADD = 4'h3, OP_ADDC = 4'h4,
                         OP_SUB = 4'h5, OP_SUBR = 4'h6, OP_AND = 4'h7, OP_OR = 4'h8,
                         OP_XOR = 4'h9, OP_NOT = 4'hA, OP_SHL = 4'hB, OP_SHR = 4'hC,
                         OP_ASR = 4'hD, OP_MUL = 4'hE;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t             r_state;
  logic [3:0]         r_op;
  logic [SHW:0]       r_cnt;
  logic [2*WIDTH-1:0] r_x;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_y;
  logic               r_cst;
  logic [WIDTH-1:0]   r_result;
  logic [3:0]         r_flags;
  logic               r_out_valid;

  logic [WIDTH:0]     w_sum, w_dab, w_dba;
  logic [WIDTH-1:0]   w_res;
  logic               w_c, w_v, w_is_shift;
  logic [WIDTH-1:0]   w_step_res;
  logic               w_step_c;
  logic [2*WIDTH-1:0] w_acc_next, w_x_next;

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign flags     = r_flags;

  assign w_is_shift = (op == OP_SHL) || (op == OP_SHR) || (op == OP_ASR);
  assign w_sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, (op == OP_ADDC) && r_cst};
  assign w_dab = {1'b0, a} - {1'b0, b};
  assign w_dba = {1'b0, b} - {1'b0, a};

  // Single-cycle results, computed straight from the operands at the accepting edge
  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (op)
      OP_PASSA: w_res = a;
      OP_PASSB: w_res = b;
      OP_ADD, OP_ADDC: begin
        w_res = w_sum[MSB:0];
        w_c   = w_sum[WIDTH];
        w_v   = (a[MSB] == b[MSB]) && (w_sum[MSB] != a[MSB]);
      end
      OP_SUB: begin
        w_res = w_dab[MSB:0];
        w_c   = w_dab[WIDTH];
        w_v   = (a[MSB] != b[MSB]) && (w_dab[MSB] != a[MSB]);
      end
      OP_SUBR: begin
        w_res = w_dba[MSB:0];
        w_c   = w_dba[WIDTH];
        w_v   = (a[MSB] != b[MSB]) && (w_dba[MSB] != b[MSB]);
      end
      OP_AND: w_res = a & b;
      OP_OR:  w_res = a | b;
      OP_XOR: w_res = a ^ b;
      OP_NOT: w_res = ~a;
      OP_SHL, OP_SHR, OP_ASR: w_res = a;  // only reached with a zero shift count
      default: w_res = '0;
    endcase
  end

  // One iterative step: a single-bit shift or one shift-and-add partial product
  always_comb begin
    w_acc_next = r_acc + (r_y[0] ? r_x : '0);
    w_step_res = '0;
    w_step_c   = 1'b0;
    w_x_next   = r_x << 1;
    case (r_op)
      OP_SHL: begin
        w_step_res = {r_x[MSB-1:0], 1'b0};
        w_step_c   = r_x[MSB];
      end
      OP_SHR: begin
        w_step_res = {1'b0, r_x[MSB:1]};
        w_step_c   = r_x[0];
      end
      OP_ASR: begin
        w_step_res = {r_x[MSB], r_x[MSB:1]};
        w_step_c   = r_x[0];
      end
      default: begin
        w_step_res = w_acc_next[MSB:0];
        w_step_c   = |w_acc_next[2*WIDTH-1:WIDTH];
      end
    endcase
    if (r_op != OP_MUL) w_x_next = {{WIDTH{1'b0}}, w_step_res};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_op        <= '0;
      r_cnt       <= '0;
      r_x         <= '0;
      r_acc       <= '0;
      r_y         <= '0;
      r_cst       <= 1'b0;
      r_result    <= '0;
      r_flags     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_op <= op;
            r_x  <= {{WIDTH{1'b0}}, a};
            r_y  <= b;
            r_acc <= '0;
            if (op == OP_MUL) begin
              r_cnt   <= (SHW + 1)'(WIDTH);
              r_state <= S_BUSY;
            end else if (w_is_shift && (b[SHW-1:0] != '0)) begin
              r_cnt   <= {1'b0, b[SHW-1:0]};
              r_state <= S_BUSY;
            end else begin
              r_result    <= w_res;
              r_flags     <= {w_res[MSB], (w_res == '0), w_c, w_v};
              r_cst       <= w_c;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end
          end
        end
        S_BUSY: begin
          r_x   <= w_x_next;
          r_y   <= r_y >> 1;
          r_acc <= w_acc_next;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == (SHW + 1)'(1)) begin
            r_result    <= w_step_res;
            r_flags     <= {w_step_res[MSB], (w_step_res == '0), w_step_c, 1'b0};
            r_cst       <= w_step_c;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
